or_event_monitor: RTL and testbench
===================================

Name: or_event_monitor

Overview:
Downstream stage of the four-input OR block (mixedfouror). Consumes its 1-bit output f, which is asynchronous to clk.
- Synchronizes f into the clk domain.
- Rejects high pulses shorter than MIN_HIGH clocks.
- Counts qualified high events.
- Reports the length of each qualified high pulse.
Output feeds status/LED logic and the bench scoreboard.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on f_in (legal range 2..4).
CNT_W, 8, width of event_count and high_len.
MIN_HIGH, 3, consecutive synchronized-high cycles needed to qualify an event (legal range 1..2^CNT_W-1).

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
f_in  input  1  OR-stage output, asynchronous to clk.
enable  input  1  monitor enable; 0 forces state to IDLE.
clr  input  1  synchronous clear of event_count, overflow and high_len.
event_pulse  output  1  one-cycle registered pulse on each qualified event.
event_count  output  CNT_W  number of qualified events, saturating.
overflow  output  1  sticky; set when an event arrives with event_count already at max.
high_len  output  CNT_W  length in clocks of the last qualified high pulse, saturating.
len_valid  output  1  one-cycle pulse when high_len updates.
level  output  1  1 while state is HIGH.

Behaviour:
- Reset (rst_n=0, asynchronous): sync flops=0, state=IDLE, run_len=0. All outputs 0 immediately.
- Synchronizer:
  - f_s is the last flop of a SYNC_STAGES-deep chain.
  - The FSM acts only on f_s, never on f_in.
- FSM states are IDLE, QUAL and HIGH. Evaluated each rising edge when enable=1.
  - IDLE, f_s=1: run_len<=1. If MIN_HIGH==1, go to HIGH and fire an event; otherwise go to QUAL. IDLE, f_s=0: stay.
  - QUAL, f_s=1: run_len<=run_len+1. When run_len+1==MIN_HIGH, go to HIGH and fire an event.
  - QUAL, f_s=0: glitch. Go to IDLE, run_len<=0, no len_valid.
  - HIGH, f_s=1: run_len<=run_len+1, saturating at 2^CNT_W-1.
  - HIGH, f_s=0: go to IDLE, high_len<=run_len, len_valid<=1 for one cycle, run_len<=0.
- Firing an event:
  - event_pulse<=1 for one cycle.
  - If event_count<max, event_count<=event_count+1; otherwise hold at max and set overflow<=1.
- Latency: f_in is high at edge k and stays high. event_pulse is high in the cycle after edge k+SYNC_STAGES+MIN_HIGH-1. Defaults give k+4.
- Length: f_in is high for exactly N sampled edges (N≥MIN_HIGH). Then high_len=N, and len_valid pulses after edge k+N+SYNC_STAGES.
- enable=0:
  - State goes to IDLE and run_len to 0; no event_pulse or len_valid.
  - event_count, overflow and high_len hold.
  - Sync flops keep running.
- clr=1:
  - Clears event_count, overflow and high_len that cycle.
  - clr has priority over a simultaneous increment or length update. event_pulse and len_valid still pulse.
  - The FSM is unaffected.
- Reset mid-pulse: after release the sync flops restart at 0. A still-high f_in re-qualifies as a new event.
- All outputs are registered; no combinational path from f_in to any output.

Decomposition:
- Package or_mon_pkg holds:
  - typedef mon_state_t enum {IDLE, QUAL, HIGH};
  - default constants SYNC_STAGES_D=2, CNT_W_D=8, MIN_HIGH_D=3.
- Sub-module sync_bit is a parameterized SYNC_STAGES flop chain with async active-low reset. The top instantiates it once.
- FSM, counters and saturation logic live in or_event_monitor.

Test Plan:
- Reset, then a=b=c=d=0 for 10 clocks -> event_count=0, no pulses, all outputs 0.
- Drive a=1 for 5 clocks, then a=b=c=d=0 -> event_pulse once at k+4, event_count=1, high_len=5, len_valid once, level high during HIGH.
- Drive d=1 for 2 clocks (glitch) -> no event_pulse, no len_valid, event_count unchanged.
- CNT_W=4, 17 pulses of 4 clocks each -> event_count=15 after the 15th pulse, overflow=1 after the 16th, both held.
- clr asserted on the same edge an event qualifies -> event_pulse=1, event_count=0, overflow=0.
- rst_n low for 1 clock mid-HIGH while f stays high -> outputs 0 at once; after release, re-qualify with event_count=1 at release+SYNC_STAGES+MIN_HIGH-1.

Source files
------------

// File: rtl/or_mon_pkg.sv
// ---------------------------------------------------------------------------
// or_mon_pkg
// Shared definitions for the OR-stage event monitor.
//   mon_state_t   : monitor FSM state encoding (IDLE, QUAL, HIGH)
//   *_D constants : default parameter values used by or_event_monitor
// ---------------------------------------------------------------------------
package or_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // waiting for the synchronized input to rise
        QUAL = 2'd1,  // input high, but not yet for MIN_HIGH cycles
        HIGH = 2'd2   // qualified event in progress, measuring its length
    } mon_state_t;

    localparam int SYNC_STAGES_D = 2;
    localparam int CNT_W_D       = 8;
    localparam int MIN_HIGH_D    = 3;

endpackage : or_mon_pkg

// File: rtl/sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
// Multi-flop synchronizer that brings one asynchronous bit into the clk
// domain. The chain is cleared by reset, so after reset is released the
// output restarts from 0 no matter what the input is doing.
// Ports:
//   clk    : destination clock, rising edge
//   rst_n  : asynchronous active-low reset
//   i_d    : asynchronous input bit
//   o_q    : synchronized bit (last flop of the chain)
// ---------------------------------------------------------------------------
module sync_bit #(
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbour; with = the chain would collapse
    // into a single stage in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule : sync_bit

// File: rtl/or_event_monitor.sv
// ---------------------------------------------------------------------------
// or_event_monitor
// Watches the asynchronous output of the four-input OR stage, synchronizes
// it, rejects high pulses shorter than MIN_HIGH clocks, counts qualified
// events and reports the length of each qualified high pulse.
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   f_in        : OR-stage output, asynchronous to clk
//   enable      : 0 forces the FSM to IDLE (counters and high_len hold)
//   clr         : synchronous clear of event_count, overflow and high_len
//   event_pulse : one-cycle pulse per qualified event
//   event_count : saturating count of qualified events
//   overflow    : sticky, set by an event arriving with event_count at max
//   high_len    : saturating length in clocks of the last qualified pulse
//   len_valid   : one-cycle pulse when high_len updates
//   level       : 1 while the FSM is in HIGH
// All outputs come straight from flops; f_in only reaches them through the
// synchronizer and the FSM.
// ---------------------------------------------------------------------------
module or_event_monitor
    import or_mon_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_D,  // 2..4
    parameter int CNT_W       = CNT_W_D,
    parameter int MIN_HIGH    = MIN_HIGH_D      // 1..2^CNT_W-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_in,
    input  logic             enable,
    input  logic             clr,
    output logic             event_pulse,
    output logic [CNT_W-1:0] event_count,
    output logic             overflow,
    output logic [CNT_W-1:0] high_len,
    output logic             len_valid,
    output logic             level
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] MIN_HIGH_C = CNT_W'(MIN_HIGH);

    // Synchronized input: the FSM never looks at f_in directly.
    logic w_f_s;

    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (f_in),
        .o_q   (w_f_s)
    );

    mon_state_t       r_state;
    logic [CNT_W-1:0] r_run_len;
    logic             r_event_pulse;
    logic             r_len_valid;
    logic [CNT_W-1:0] r_event_count;
    logic             r_overflow;
    logic [CNT_W-1:0] r_high_len;

    mon_state_t       w_state_next;
    logic [CNT_W-1:0] w_run_len_next;
    logic [CNT_W-1:0] w_run_inc;
    logic             w_fire;
    logic             w_len_upd;

    // run_len never wraps here: in QUAL it stays below MIN_HIGH, and in
    // HIGH the increment is only taken below CNT_MAX.
    assign w_run_inc = r_run_len + CNT_W'(1);

    // -----------------------------------------------------------------------
    // Next-state / action decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        w_state_next   = r_state;
        w_run_len_next = r_run_len;
        w_fire         = 1'b0;
        w_len_upd      = 1'b0;

        if (!enable) begin
            w_state_next   = IDLE;
            w_run_len_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_f_s) begin
                        w_run_len_next = CNT_W'(1);
                        if (MIN_HIGH == 1) begin
                            w_state_next = HIGH;
                            w_fire       = 1'b1;
                        end else begin
                            w_state_next = QUAL;
                        end
                    end
                end

                QUAL: begin
                    if (w_f_s) begin
                        w_run_len_next = w_run_inc;
                        if (w_run_inc == MIN_HIGH_C) begin
                            w_state_next = HIGH;
                            w_fire       = 1'b1;
                        end
                    end else begin
                        // Too short: a glitch, dropped without a length report.
                        w_state_next   = IDLE;
                        w_run_len_next = '0;
                    end
                end

                HIGH: begin
                    if (w_f_s) begin
                        if (r_run_len != CNT_MAX) begin
                            w_run_len_next = w_run_inc;
                        end
                    end else begin
                        w_state_next   = IDLE;
                        w_run_len_next = '0;
                        w_len_upd      = 1'b1;
                    end
                end

                default: begin
                    w_state_next   = IDLE;
                    w_run_len_next = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State, pulses and counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_run_len     <= '0;
            r_event_pulse <= 1'b0;
            r_len_valid   <= 1'b0;
            r_event_count <= '0;
            r_overflow    <= 1'b0;
            r_high_len    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_run_len     <= w_run_len_next;
            r_event_pulse <= w_fire;
            r_len_valid   <= w_len_upd;

            // clr wins over a same-cycle increment or length update, but the
            // pulses above still go out so downstream sees the event.
            if (clr) begin
                r_event_count <= '0;
                r_overflow    <= 1'b0;
                r_high_len    <= '0;
            end else begin
                if (w_fire) begin
                    if (r_event_count != CNT_MAX) begin
                        r_event_count <= r_event_count + CNT_W'(1);
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end
                if (w_len_upd) begin
                    r_high_len <= r_run_len;
                end
            end
        end
    end

    assign event_pulse = r_event_pulse;
    assign event_count = r_event_count;
    assign overflow    = r_overflow;
    assign high_len    = r_high_len;
    assign len_valid   = r_len_valid;
    assign level       = (r_state == HIGH);

endmodule : or_event_monitor

// File: tb/tb_or_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_or_event_monitor
// Scoreboard bench for or_event_monitor (SYNC_STAGES=2, CNT_W=4, MIN_HIGH=3).
// The OR stage is modelled as f_in = a|b|c|d. Stimulus pushes the expected
// event and length reports, with the cycle they must appear in; a monitor
// pops and compares whenever event_pulse or len_valid is seen.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_or_event_monitor;

    localparam int SYNC = 2;
    localparam int MINH = 3;
    localparam int CW   = 4;
    // Inputs set at the negedge of cycle c0 are first sampled at edge c0+1.
    // Event fires at edge (c0+1)+SYNC+MINH-1, length report at (c0+1)+N+SYNC.
    localparam int EVT_OFS = SYNC + MINH;
    localparam int LEN_OFS = SYNC + 1;
    localparam int GAP     = 6;

    typedef struct { int cyc; int cnt; bit ovf; } evt_t;
    typedef struct { int cyc; int len; } len_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    abcd;  // {d, c, b, a}
    logic          f_in;
    logic          enable;
    logic          clr;
    logic          event_pulse;
    logic [CW-1:0] event_count;
    logic          overflow;
    logic [CW-1:0] high_len;
    logic          len_valid;
    logic          level;

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    evt_t evt_q[$];
    len_t len_q[$];
    evt_t e;
    len_t l;

    assign f_in = |abcd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    or_event_monitor #(
        .SYNC_STAGES (SYNC),
        .CNT_W       (CW),
        .MIN_HIGH    (MINH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_in        (f_in),
        .enable      (enable),
        .clr         (clr),
        .event_pulse (event_pulse),
        .event_count (event_count),
        .overflow    (overflow),
        .high_len    (high_len),
        .len_valid   (len_valid),
        .level       (level)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: every observed pulse must match the head of its queue.
    always @(negedge clk) begin
        if (event_pulse === 1'b1) begin
            if (evt_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL evt_unexpected @cyc %0d: got event_pulse=1, required 0", cyc);
            end else begin
                e = evt_q.pop_front();
                check("evt_cycle", cyc, e.cyc);
                check("evt_count", int'(event_count), e.cnt);
                check("evt_overflow", int'(overflow), int'(e.ovf));
                check("evt_level", int'(level), 1);
            end
        end
        if (len_valid === 1'b1) begin
            if (len_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL len_unexpected @cyc %0d: got len_valid=1, required 0", cyc);
            end else begin
                l = len_q.pop_front();
                check("len_cycle", cyc, l.cyc);
                check("len_value", int'(high_len), l.len);
                check("len_level", int'(level), 0);
            end
        end
    end

    // Drive input src high for n sampled edges, then idle for GAP cycles.
    // clr is held high for the edge c0+clr_at (0 = never). Called at a negedge.
    task automatic pulse(input int src, input int n, input bit ev, input int cnt,
                         input bit ovf, input bit lv, input int len, input int clr_at);
        int c0 = cyc;
        if (ev) evt_q.push_back('{c0 + EVT_OFS, cnt, ovf});
        if (lv) len_q.push_back('{c0 + n + LEN_OFS, len});
        for (int t = 1; t <= n + GAP; t++) begin
            abcd[src] = (t <= n);
            clr       = (t == clr_at);
            @(negedge clk);
        end
        abcd = '0;
        clr  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_event_pulse"}, int'(event_pulse), 0);
        check({tag, "_event_count"}, int'(event_count), 0);
        check({tag, "_overflow"},    int'(overflow),    0);
        check({tag, "_high_len"},    int'(high_len),    0);
        check({tag, "_len_valid"},   int'(len_valid),   0);
        check({tag, "_level"},       int'(level),       0);
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst_n  = 1'b0;
        abcd   = '0;
        enable = 1'b1;
        clr    = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("in_reset");
        rst_n = 1'b1;

        // Quiet input for 10 clocks: nothing happens.
        repeat (10) @(negedge clk);
        check_idle_outputs("quiet");

        // a high for 5 clocks: event at +5, high_len 5.
        pulse(0, 5, 1, 1, 0, 1, 5, 0);
        // d high for 2 clocks: glitch, rejected.
        pulse(3, 2, 0, 0, 0, 0, 0, 0);
        check("glitch_count", int'(event_count), 1);
        check("glitch_len", int'(high_len), 5);
        // b high for 20 clocks: high_len saturates at 15.
        pulse(1, 20, 1, 2, 0, 1, 15, 0);
        // c high for exactly MIN_HIGH clocks: qualifies.
        pulse(2, 3, 1, 3, 0, 1, 3, 0);

        // Disabled: a long pulse is ignored, counters hold.
        enable = 1'b0;
        pulse(0, 6, 0, 0, 0, 0, 0, 0);
        enable = 1'b1;
        check("disabled_count", int'(event_count), 3);
        check("disabled_len", int'(high_len), 3);

        // clr on the qualifying edge: pulse still fires, count reads 0.
        pulse(0, 6, 1, 0, 0, 1, 6, EVT_OFS);
        // clr on the length-update edge: len_valid fires, high_len reads 0.
        pulse(0, 5, 1, 1, 0, 1, 0, 5 + LEN_OFS);
        check("clr_len_after", int'(high_len), 0);

        // Clear, then 17 four-clock pulses: saturation at 15, overflow on 16th.
        pulse(0, 0, 0, 0, 0, 0, 0, 1);
        check("clr_count", int'(event_count), 0);
        for (int i = 1; i <= 17; i++) begin
            pulse(i % 4, 4, 1, (i < 15) ? i : 15, (i >= 16), 1, 4, 0);
        end
        check("sat_count", int'(event_count), 15);
        check("sat_overflow", int'(overflow), 1);

        // Reset for one clock in the middle of a HIGH pulse.
        c0      = cyc;
        abcd[0] = 1'b1;
        evt_q.push_back('{c0 + EVT_OFS, 15, 1'b1});
        repeat (7) @(negedge clk);
        check("pre_reset_level", int'(level), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release is c0+9; input stays high through edge c0+16.
        evt_q.push_back('{c0 + 9 + SYNC + MINH - 1, 1, 1'b0});
        len_q.push_back('{c0 + 9 + 8 + SYNC, 8});
        repeat (8) @(negedge clk);
        abcd = '0;
        repeat (GAP) @(negedge clk);
        check("final_count", int'(event_count), 1);
        check("final_overflow", int'(overflow), 0);

        check("evt_left_unseen", evt_q.size(), 0);
        check("len_left_unseen", len_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_or_event_monitor
